// File: rtl/athos_ip_x_heep_pkg.sv
// Shared types and constants for the athos_ip wrapper: job opcodes, job descriptor,
// scheduler FSM states and the slave-window geometry.
package athos_ip_x_heep_pkg;

  localparam int unsigned ATHOS_IP_SIZE      = 32'h0020_0000;
  localparam int unsigned ATHOS_SLAVE_ADDR_W = $clog2(ATHOS_IP_SIZE);
  localparam int unsigned ATHOS_POLY_BYTES   = 512;

  typedef enum logic [1:0] {
    ATHOS_NTT  = 2'd0,
    ATHOS_INTT = 2'd1,
    ATHOS_PWM  = 2'd2,
    ATHOS_RSVD = 2'd3
  } athos_op_e;

  typedef struct packed {
    athos_op_e                     op;
    logic [ATHOS_SLAVE_ADDR_W-1:0] src;
    logic [ATHOS_SLAVE_ADDR_W-1:0] dst;
  } athos_job_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2,
    SCHED_ABORT = 2'd3
  } athos_sched_state_e;

endpackage

// File: rtl/athos_job_fifo.sv
// Synchronous circular FIFO of job descriptors with an occupancy count and a
// single-cycle flush that empties it.
module athos_job_fifo
  import athos_ip_x_heep_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  athos_job_t       push_data,
  input  logic             pop,
  output athos_job_t       head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  athos_job_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can take a new entry when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/athos_job_scheduler.sv
// Queues compute jobs from the register front-end, issues them one at a time to the
// engine, and tracks completion, watchdog timeouts and the CPU interrupt.
module athos_job_scheduler
  import athos_ip_x_heep_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned ADDR_W         = ATHOS_SLAVE_ADDR_W,
  parameter int unsigned POLY_BYTES     = ATHOS_POLY_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [1:0]                   cmd_op_i,
  input  logic [ADDR_W-1:0]            cmd_src_i,
  input  logic [ADDR_W-1:0]            cmd_dst_i,
  output logic                         cmd_reject_o,
  input  logic                         flush_i,
  output logic                         eng_start_o,
  output logic [1:0]                   eng_op_o,
  output logic [ADDR_W-1:0]            eng_src_o,
  output logic [ADDR_W-1:0]            eng_dst_o,
  input  logic                         eng_done_i,
  output logic                         eng_abort_o,
  output logic                         busy_o,
  output logic [$clog2(QUEUE_DEPTH):0] q_count_o,
  output logic [15:0]                  jobs_done_o,
  output logic                         err_timeout_o,
  output logic                         irq_o,
  input  logic                         irq_clear_i
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QUEUE_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  // Highest start offset at which a whole polynomial still fits in the window.
  localparam logic [ADDR_W:0]  OFF_LIMIT = (ADDR_W+1)'((64'd1 << ADDR_W) - 64'(POLY_BYTES));

  function automatic logic offset_legal(input logic [ADDR_W-1:0] off);
    return (off[1:0] == 2'b00) && ({1'b0, off} <= OFF_LIMIT);
  endfunction

  athos_sched_state_e state_q, state_d;
  athos_job_t         push_job, head_job, act_q;
  logic [CNT_W-1:0]   q_count;
  logic [WD_W-1:0]    wdog_q;
  logic [15:0]        jobs_done_q;
  logic               fifo_empty;
  logic               push_hs, job_legal, pop;
  logic               wd_clr, wd_inc, done_evt, to_evt;
  logic               reject_p1, irq_q, err_q;

  assign cmd_ready_o = (q_count < Q_FULL) & ~flush_i;
  assign push_hs     = cmd_valid_i & cmd_ready_o;
  assign job_legal   = (cmd_op_i != 2'd3) && offset_legal(cmd_src_i) && offset_legal(cmd_dst_i);
  assign push_job    = '{op:  athos_op_e'(cmd_op_i),
                         src: ATHOS_SLAVE_ADDR_W'(cmd_src_i),
                         dst: ATHOS_SLAVE_ADDR_W'(cmd_dst_i)};

  athos_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push      (push_hs & job_legal),
    .push_data (push_job),
    .pop       (pop),
    .head      (head_job),
    .empty     (fifo_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SCHED_IDLE;
    else       state_q <= state_d;
  end

  // Flush outranks both done and the watchdog; done outranks the watchdog.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    done_evt = 1'b0;
    to_evt   = 1'b0;
    unique case (state_q)
      SCHED_IDLE: begin
        if (!flush_i && !fifo_empty) begin
          pop     = 1'b1;
          state_d = SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = flush_i ? SCHED_ABORT : SCHED_WAIT;
      end
      SCHED_WAIT: begin
        if (flush_i) begin
          state_d = SCHED_ABORT;
        end else if (eng_done_i) begin
          done_evt = 1'b1;
          state_d  = SCHED_IDLE;
        end else if (wdog_q == WD_LAST) begin
          to_evt  = 1'b1;
          state_d = SCHED_ABORT;
        end else begin
          wd_inc = 1'b1;
        end
      end
      SCHED_ABORT: state_d = SCHED_IDLE;
      default:     state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q       <= '0;
      wdog_q      <= '0;
      jobs_done_q <= '0;
      reject_p1   <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (pop) act_q <= head_job;
      if (wd_clr)      wdog_q <= '0;
      else if (wd_inc) wdog_q <= wdog_q + 1'b1;
      if (done_evt) jobs_done_q <= jobs_done_q + 1'b1;
      reject_p1 <= push_hs & ~job_legal;
      if (done_evt || to_evt) irq_q <= 1'b1;
      else if (irq_clear_i)   irq_q <= 1'b0;
      if (to_evt)           err_q <= 1'b1;
      else if (irq_clear_i) err_q <= 1'b0;
    end
  end

  assign eng_start_o   = (state_q == SCHED_ISSUE);
  assign eng_abort_o   = (state_q == SCHED_ABORT);
  assign busy_o        = (state_q != SCHED_IDLE);
  assign eng_op_o      = act_q.op;
  assign eng_src_o     = ADDR_W'(act_q.src);
  assign eng_dst_o     = ADDR_W'(act_q.dst);
  assign q_count_o     = q_count;
  assign jobs_done_o   = jobs_done_q;
  assign cmd_reject_o  = reject_p1;
  assign err_timeout_o = err_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_athos_job_scheduler.sv
// Directed bench for athos_job_scheduler: single job, queue fill/drain, illegal jobs,
// watchdog timeout, flush and mid-job reset.
module tb_athos_job_scheduler;

  localparam int unsigned QD = 4;
  localparam int unsigned AW = 21;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              rst, cmd_valid, flush, eng_done, irq_clear;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_src, cmd_dst;
  logic              cmd_ready, cmd_reject, eng_start, eng_abort, busy, err_timeout, irq;
  logic [1:0]        eng_op;
  logic [AW-1:0]     eng_src, eng_dst;
  logic [$clog2(QD):0] q_count;
  logic [15:0]       jobs_done;

  int tests  = 0;
  int fails  = 0;
  int exp_jd = 0;
  logic [1:0]    t_op  [5];
  logic [AW-1:0] t_src [5];
  logic [AW-1:0] t_dst [5];

  always #5 clk = ~clk;

  athos_job_scheduler #(
    .QUEUE_DEPTH(QD), .ADDR_W(AW), .POLY_BYTES(512), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_reject_o(cmd_reject),
    .flush_i(flush), .eng_start_o(eng_start), .eng_op_o(eng_op),
    .eng_src_o(eng_src), .eng_dst_o(eng_dst), .eng_done_i(eng_done),
    .eng_abort_o(eng_abort), .busy_o(busy), .q_count_o(q_count),
    .jobs_done_o(jobs_done), .err_timeout_o(err_timeout), .irq_o(irq),
    .irq_clear_i(irq_clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0; eng_done = 1'b0; irq_clear = 1'b0;
    cmd_op = '0; cmd_src = '0; cmd_dst = '0;
    for (int i = 0; i < 5; i++) begin
      t_op[i]  = 2'(i % 3);
      t_src[i] = AW'(32'h1000 + i * 32'h200);
      t_dst[i] = AW'(32'h8000 + i * 32'h200);
    end
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_qcount", 32'(q_count), 0);
    chk("rst_jobs_done", 32'(jobs_done), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_abort", 32'(eng_abort), 0);
    chk("rst_reject", 32'(cmd_reject), 0);

    // Single job: start two cycles after the handshake
    set_cmd(2'd0, 21'h000, 21'h200);
    tick();
    cmd_valid = 1'b0;
    chk("t1_start_early", 32'(eng_start), 0);
    chk("t1_qcount_1", 32'(q_count), 1);
    tick();
    chk("t1_start", 32'(eng_start), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_op", 32'(eng_op), 0);
    chk("t1_src", 32'(eng_src), 32'h000);
    chk("t1_dst", 32'(eng_dst), 32'h200);
    tick();
    chk("t1_start_pulse", 32'(eng_start), 0);
    repeat (8) tick();
    chk("t1_dst_held", 32'(eng_dst), 32'h200);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    exp_jd++;
    chk("t1_jobs_done", 32'(jobs_done), 32'(exp_jd));
    chk("t1_irq", 32'(irq), 1);
    chk("t1_err", 32'(err_timeout), 0);
    chk("t1_idle", 32'(busy), 0);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk("t1_irq_clr", 32'(irq), 0);

    // Five back-to-back pushes with the engine stalled
    for (int i = 0; i < 5; i++) begin
      set_cmd(t_op[i], t_src[i], t_dst[i]);
      tick();
    end
    chk("t2_qcount_full", 32'(q_count), 4);
    chk("t2_ready_full", 32'(cmd_ready), 0);
    set_cmd(2'd1, 21'h4000, 21'h4200);
    tick();
    cmd_valid = 1'b0;
    chk("t2_no_overflow", 32'(q_count), 4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_op%0d", k), 32'(eng_op), 32'(t_op[k]));
      chk($sformatf("t2_src%0d", k), 32'(eng_src), 32'(t_src[k]));
      chk($sformatf("t2_dst%0d", k), 32'(eng_dst), 32'(t_dst[k]));
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      exp_jd++;
      chk($sformatf("t2_done%0d", k), 32'(jobs_done), 32'(exp_jd));
      if (k < 4) begin
        tick();
        chk($sformatf("t2_start%0d", k + 1), 32'(eng_start), 1);
        chk($sformatf("t2_qcount%0d", k + 1), 32'(q_count), 32'(3 - k));
        tick();
      end
    end
    chk("t2_drained_busy", 32'(busy), 0);
    chk("t2_drained_q", 32'(q_count), 0);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;

    // Illegal jobs: reserved op, misaligned src, misaligned dst, out-of-window src
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_cmd(2'd3, 21'h000, 21'h000);
        1: set_cmd(2'd0, 21'h002, 21'h000);
        2: set_cmd(2'd0, 21'h000, 21'h1FFE01);
        default: set_cmd(2'd0, 21'h1FFE04, 21'h000);
      endcase
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("t3_reject%0d", i), 32'(cmd_reject), 1);
      chk($sformatf("t3_q%0d", i), 32'(q_count), 0);
      tick();
      chk($sformatf("t3_reject_pulse%0d", i), 32'(cmd_reject), 0);
      chk($sformatf("t3_no_start%0d", i), 32'(eng_start | busy), 0);
    end

    // Watchdog: boundary-legal job times out, queued job follows
    set_cmd(2'd2, 21'h1FFE00, 21'h1FFE00);
    tick();
    chk("t4_boundary_ok", 32'(cmd_reject), 0);
    chk("t4_q1", 32'(q_count), 1);
    set_cmd(2'd1, 21'h400, 21'h800);
    tick();
    cmd_valid = 1'b0;
    chk("t4_startA", 32'(eng_start), 1);
    chk("t4_srcA", 32'(eng_src), 32'h1FFE00);
    chk("t4_opA", 32'(eng_op), 2);
    tick();
    repeat (TO - 1) tick();
    chk("t4_err_early", 32'(err_timeout), 0);
    chk("t4_abort_early", 32'(eng_abort), 0);
    chk("t4_busy_wait", 32'(busy), 1);
    tick();
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_irq", 32'(irq), 1);
    chk("t4_abort", 32'(eng_abort), 1);
    tick();
    chk("t4_abort_pulse", 32'(eng_abort), 0);
    chk("t4_idle", 32'(busy), 0);
    tick();
    chk("t4_startB", 32'(eng_start), 1);
    chk("t4_srcB", 32'(eng_src), 32'h400);
    chk("t4_opB", 32'(eng_op), 1);
    chk("t4_err_sticky", 32'(err_timeout), 1);
    tick();
    eng_done = 1'b1;
    irq_clear = 1'b1;
    tick();
    eng_done = 1'b0;
    irq_clear = 1'b0;
    exp_jd++;
    chk("t4_doneB", 32'(jobs_done), 32'(exp_jd));
    chk("t4_irq_set_wins", 32'(irq), 1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk("t4_irq_clr", 32'(irq), 0);
    chk("t4_err_clr", 32'(err_timeout), 0);

    // Flush in WAIT with three queued jobs and a coincident done
    for (int i = 0; i < 4; i++) begin
      set_cmd(t_op[i], t_src[i], t_dst[i]);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t5_q3", 32'(q_count), 3);
    chk("t5_busy", 32'(busy), 1);
    flush = 1'b1;
    eng_done = 1'b1;
    #1;
    chk("t5_ready_flush", 32'(cmd_ready), 0);
    tick();
    flush = 1'b0;
    eng_done = 1'b0;
    chk("t5_q0", 32'(q_count), 0);
    chk("t5_abort", 32'(eng_abort), 1);
    chk("t5_done_ignored", 32'(jobs_done), 32'(exp_jd));
    chk("t5_irq", 32'(irq), 0);
    tick();
    chk("t5_abort_pulse", 32'(eng_abort), 0);
    chk("t5_idle", 32'(busy), 0);
    tick();
    chk("t5_no_restart", 32'(eng_start | busy), 0);

    // Reset while a job is in WAIT
    set_cmd(2'd1, 21'h600, 21'h800);
    tick();
    set_cmd(2'd2, 21'hA00, 21'hC00);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_q", 32'(q_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_q", 32'(q_count), 0);
    chk("t6_jobs_done", 32'(jobs_done), 0);
    chk("t6_op", 32'(eng_op), 0);
    chk("t6_src", 32'(eng_src), 0);
    chk("t6_dst", 32'(eng_dst), 0);
    chk("t6_abort", 32'(eng_abort), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t6_done_ignored", 32'(jobs_done), 0);
    chk("t6_irq", 32'(irq), 0);
    tick();
    chk("t6_quiet", 32'(eng_start | busy | eng_abort), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
